// File: rtl/cla_pipe_nb_pkg.sv
// Shared constants and types for the pipelined carry-lookahead adder/subtractor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   GRP_W        width of one lookahead group (one pipeline stage resolves one group)
//   MIN_BW       smallest supported operand width
//   mode_e       add / subtract selector as seen on i_sub
//   grp_out_t    bundled result of one 4-bit lookahead group
//   bw_data_ok() elaboration-time legality check for the operand width
package cla_pipe_nb_pkg;

  localparam int GRP_W  = 4;
  localparam int MIN_BW = 8;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  typedef struct packed {
    logic [GRP_W-1:0] s;
    logic             cout;
    logic             c3;    // carry into the group MSB, used for signed overflow
  } grp_out_t;

  // True when the operand width splits evenly into lookahead groups and is
  // wide enough to give at least two pipeline stages.
  function automatic bit bw_data_ok(input int bw);
    return ((bw % GRP_W) == 0) && (bw >= MIN_BW);
  endfunction

endpackage

// File: rtl/cla_grp4.sv
// Combinational 4-bit carry-lookahead group: every internal carry is a flat
// sum-of-products of generate/propagate terms and cin, with no ripple chain.
// Latency: 0 cycles (purely combinational). Backpressure: none (no state).
//
// Ports:
//   a, b  4-bit operand slices
//   cin   carry into bit 0
//   s     4-bit sum slice
//   cout  carry out of bit 3
//   c3    carry into bit 3 (cout ^ c3 is signed overflow when this is the top group)
module cla_grp4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       c3
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;

  assign g = a & b;
  assign p = a ^ b;

  assign c1 = g[0]
            | (p[0] & cin);

  assign c2 = g[1]
            | (p[1] & g[0])
            | (p[1] & p[0] & cin);

  assign c3 = g[2]
            | (p[2] & g[1])
            | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & cin);

  assign cout = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/cla_pipe_nb.sv
// Pipelined adder/subtractor resolving one 4-bit lookahead group per stage.
// Latency: BW_DATA/4 cycles from accept to o_vld; one result per cycle.
// Backpressure: whole pipe freezes while o_vld=1 and i_rdy=0; o_rdy mirrors that.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_vld / o_rdy         input handshake (o_rdy never depends on i_vld)
//   i_a, i_b, i_c, i_sub  operands, carry/borrow in, mode (0 = A+B+c, 1 = A-B-c)
//   o_vld / i_rdy         output handshake
//   o_s, o_c, o_ov        sum/difference, carry out (1 = no borrow in subtract), signed overflow
module cla_pipe_nb
  import cla_pipe_nb_pkg::*;
#(
  parameter int BW_DATA = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_vld,
  output logic               o_rdy,
  input  logic [BW_DATA-1:0] i_a,
  input  logic [BW_DATA-1:0] i_b,
  input  logic               i_c,
  input  logic               i_sub,
  output logic               o_vld,
  input  logic               i_rdy,
  output logic [BW_DATA-1:0] o_s,
  output logic               o_c,
  output logic               o_ov
);

  localparam int NGRP = BW_DATA / GRP_W;

  if (!bw_data_ok(BW_DATA)) begin : g_bw_chk
    $error("cla_pipe_nb: BW_DATA=%0d must be a multiple of %0d and >= %0d",
           BW_DATA, GRP_W, MIN_BW);
  end

  // Stage k registers. a/b carry the operands forward so later stages can
  // pick up their own group; s accumulates the groups already resolved.
  logic               vld_q [NGRP];
  logic               vld_d [NGRP];
  logic [BW_DATA-1:0] a_q   [NGRP];
  logic [BW_DATA-1:0] a_d   [NGRP];
  logic [BW_DATA-1:0] b_q   [NGRP];
  logic [BW_DATA-1:0] b_d   [NGRP];
  logic [BW_DATA-1:0] s_q   [NGRP];
  logic [BW_DATA-1:0] s_d   [NGRP];
  logic               cy_q  [NGRP];
  logic               cy_d  [NGRP];
  logic               ov_q;
  logic               ov_d;

  grp_out_t           grp   [NGRP];

  logic               adv;
  mode_e              mode;
  logic [BW_DATA-1:0] b_eff;
  logic               cin_eff;

  // Subtract is A + ~B + ~c. The mode is folded into B and the carry here,
  // once, so nothing downstream ever looks at live i_sub.
  assign mode    = mode_e'(i_sub);
  assign b_eff   = (mode == MODE_SUB) ? ~i_b : i_b;
  assign cin_eff = (mode == MODE_SUB) ? ~i_c : i_c;

  // Single global advance: a full output register that cannot retire blocks
  // every stage, so nothing is dropped and no per-stage credit is needed.
  assign adv   = ~vld_q[NGRP-1] | i_rdy;
  assign o_rdy = adv;

  for (genvar k = 0; k < NGRP; k++) begin : g_stage
    logic [GRP_W-1:0] ga;
    logic [GRP_W-1:0] gb;
    logic             gc;
    logic [GRP_W-1:0] gs;
    logic             gco;
    logic             gc3;

    if (k == 0) begin : g_head
      assign ga = i_a[GRP_W-1:0];
      assign gb = b_eff[GRP_W-1:0];
      assign gc = cin_eff;
    end else begin : g_body
      assign ga = a_q[k-1][GRP_W*k +: GRP_W];
      assign gb = b_q[k-1][GRP_W*k +: GRP_W];
      assign gc = cy_q[k-1];
    end

    cla_grp4 u_grp (
      .a    (ga),
      .b    (gb),
      .cin  (gc),
      .s    (gs),
      .cout (gco),
      .c3   (gc3)
    );

    assign grp[k] = '{s: gs, cout: gco, c3: gc3};
  end

  always_comb begin
    vld_d = vld_q;
    a_d   = a_q;
    b_d   = b_q;
    s_d   = s_q;
    cy_d  = cy_q;
    ov_d  = ov_q;

    if (adv) begin
      // Stage 0 takes the live inputs; bubbles simply load vld=0.
      vld_d[0]              = i_vld;
      a_d[0]                = i_a;
      b_d[0]                = b_eff;
      s_d[0]                = '0;
      s_d[0][GRP_W-1:0]     = grp[0].s;
      cy_d[0]               = grp[0].cout;

      for (int k = 1; k < NGRP; k++) begin
        vld_d[k]                   = vld_q[k-1];
        a_d[k]                     = a_q[k-1];
        b_d[k]                     = b_q[k-1];
        s_d[k]                     = s_q[k-1];
        s_d[k][GRP_W*k +: GRP_W]   = grp[k].s;
        cy_d[k]                    = grp[k].cout;
      end

      // Only the top group's carries define signed overflow.
      ov_d = grp[NGRP-1].cout ^ grp[NGRP-1].c3;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < NGRP; k++) begin
        vld_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
        cy_q[k]  <= 1'b0;
      end
      ov_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      a_q   <= a_d;
      b_q   <= b_d;
      s_q   <= s_d;
      cy_q  <= cy_d;
      ov_q  <= ov_d;
    end
  end

  assign o_vld = vld_q[NGRP-1];
  assign o_s   = s_q[NGRP-1];
  assign o_c   = cy_q[NGRP-1];
  assign o_ov  = ov_q;

endmodule
